// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: two source handshakes, sink handshake and owner select
interface mux_rr_arbiter_if #(parameter int WIDTH = 8);
  logic             p_valid;
  logic [WIDTH-1:0] p;
  logic             p_ready;
  logic             q_valid;
  logic [WIDTH-1:0] q;
  logic             q_ready;
  logic             y_valid;
  logic [WIDTH-1:0] y_out;
  logic             y_ready;
  logic             sel;
  modport slave  (input p_valid, p, q_valid, q, y_ready,
                  output p_ready, q_ready, y_valid, y_out, sel);
  modport master (output p_valid, p, q_valid, q, y_ready,
                  input p_ready, q_ready, y_valid, y_out, sel);
endinterface

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: two-source round-robin arbiter with burst limit and registered output
module mux_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input logic               clk,
  input logic               rst_n,
  mux_rr_arbiter_if.slave   bus
);
  logic [WIDTH-1:0] r_y;
  logic             r_y_valid;
  logic             r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic             w_load;
  logic             w_xfer;
  logic             w_choice;
  logic             w_both;
  // With both requesting, the owner keeps the channel until its burst is used up
  assign w_both   = bus.p_valid && bus.q_valid;
  assign w_choice = w_both ? ((r_cnt < CNT_W'(MAX_BURST)) ? r_sel : !r_sel) : bus.q_valid;
  assign w_load   = !r_y_valid || bus.y_ready;
  assign w_xfer   = rst_n && w_load && (bus.p_valid || bus.q_valid);
  assign bus.p_ready = w_xfer && bus.p_valid && !w_choice;
  assign bus.q_ready = w_xfer && bus.q_valid && w_choice;
  assign bus.y_valid = r_y_valid;
  assign bus.y_out   = r_y;
  assign bus.sel     = r_sel;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_sel     <= 1'b0;
      r_cnt     <= '0;
    end else if (w_xfer) begin
      r_y       <= w_choice ? bus.q : bus.p;
      r_y_valid <= 1'b1;
      if (w_choice == r_sel) begin
        r_cnt <= (r_cnt == CNT_W'(MAX_BURST)) ? r_cnt : r_cnt + 1'b1;
      end else begin
        r_sel <= w_choice;
        r_cnt <= CNT_W'(1);
      end
    end else if (bus.y_ready) begin
      r_y_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed scenario tests for the round-robin arbiter
module tb_mux_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  mux_rr_arbiter_if #(.WIDTH(8)) bus();
  mux_rr_arbiter #(.WIDTH(8), .MAX_BURST(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.p_valid = 0; bus.q_valid = 0; bus.p = 0; bus.q = 0; bus.y_ready = 1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    bus.p_valid = 1; bus.q_valid = 1; bus.p = 8'h01; bus.q = 8'h02; bus.y_ready = 1;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.y_valid !== 1'b0 || bus.y_out !== 8'h00 || bus.sel !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: y_valid=%b y_out=%h sel=%b want 0 00 0", bus.y_valid, bus.y_out, bus.sel);
    end
    checks++;
    if (bus.p_ready !== 1'b0 || bus.q_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: p_ready=%b q_ready=%b want 0 0", bus.p_ready, bus.q_ready);
    end
    rst_n = 1;
    #1;
    checks++;
    if (bus.p_ready !== 1'b1 || bus.q_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_grant: p_ready=%b q_ready=%b want 1 0", bus.p_ready, bus.q_ready);
    end
    cyc();
    checks++;
    if (bus.y_valid !== 1'b1 || bus.y_out !== 8'h01) begin
      errors++;
      $display("FAIL reset_first_word: y_valid=%b y_out=%h want 1 01", bus.y_valid, bus.y_out);
    end
  endtask

  task automatic test_p_only();
    logic [7:0] v [3] = '{8'h11, 8'h22, 8'h33};
    do_reset();
    bus.p_valid = 1;
    for (int i = 0; i < 3; i++) begin
      bus.p = v[i];
      #1;
      checks++;
      if (bus.p_ready !== 1'b1 || bus.q_ready !== 1'b0) begin
        errors++;
        $display("FAIL p_only_ready[%0d]: p_ready=%b q_ready=%b want 1 0", i, bus.p_ready, bus.q_ready);
      end
      cyc();
      checks++;
      if (bus.y_out !== v[i] || bus.y_valid !== 1'b1 || bus.sel !== 1'b0) begin
        errors++;
        $display("FAIL p_only_out[%0d]: y_out=%h y_valid=%b sel=%b want %h 1 0", i, bus.y_out, bus.y_valid, bus.sel, v[i]);
      end
    end
    bus.p_valid = 0;
    cyc();
    checks++;
    if (bus.y_valid !== 1'b0 || bus.y_out !== 8'h33) begin
      errors++;
      $display("FAIL p_only_drain: y_valid=%b y_out=%h want 0 33", bus.y_valid, bus.y_out);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_y [10] = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h55, 8'h55, 8'h55, 8'h55, 8'hAA, 8'hAA};
    do_reset();
    bus.p_valid = 1; bus.q_valid = 1; bus.p = 8'hAA; bus.q = 8'h55;
    for (int i = 0; i < 10; i++) begin
      logic want_q;
      want_q = (exp_y[i] == 8'h55);
      #1;
      checks++;
      if (bus.p_ready !== !want_q || bus.q_ready !== want_q) begin
        errors++;
        $display("FAIL rr_ready[%0d]: p_ready=%b q_ready=%b want %b %b", i, bus.p_ready, bus.q_ready, !want_q, want_q);
      end
      cyc();
      checks++;
      if (bus.y_out !== exp_y[i] || bus.sel !== want_q || bus.y_valid !== 1'b1) begin
        errors++;
        $display("FAIL rr_out[%0d]: y_out=%h sel=%b y_valid=%b want %h %b 1", i, bus.y_out, bus.sel, bus.y_valid, exp_y[i], want_q);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.p_valid = 1; bus.p = 8'h3C;
    cyc();
    bus.y_ready = 0;
    for (int i = 0; i < 5; i++) begin
      bus.p = 8'(8'h40 + i);
      #1;
      checks++;
      if (bus.p_ready !== 1'b0 || bus.q_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready[%0d]: p_ready=%b q_ready=%b want 0 0", i, bus.p_ready, bus.q_ready);
      end
      cyc();
      checks++;
      if (bus.y_out !== 8'h3C || bus.y_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: y_out=%h y_valid=%b want 3c 1", i, bus.y_out, bus.y_valid);
      end
    end
    bus.y_ready = 1; bus.p = 8'h5A;
    #1;
    checks++;
    if (bus.p_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: p_ready=%b want 1", bus.p_ready);
    end
    cyc();
    checks++;
    if (bus.y_out !== 8'h5A || bus.y_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_out: y_out=%h y_valid=%b want 5a 1", bus.y_out, bus.y_valid);
    end
  endtask

  task automatic test_owner_drop();
    do_reset();
    bus.p_valid = 1; bus.p = 8'h01;
    cyc();
    bus.p = 8'h02;
    cyc();
    bus.p_valid = 0; bus.q_valid = 1; bus.q = 8'h77;
    #1;
    checks++;
    if (bus.q_ready !== 1'b1 || bus.p_ready !== 1'b0) begin
      errors++;
      $display("FAIL drop_ready: p_ready=%b q_ready=%b want 0 1", bus.p_ready, bus.q_ready);
    end
    cyc();
    checks++;
    if (bus.y_out !== 8'h77 || bus.sel !== 1'b1) begin
      errors++;
      $display("FAIL drop_switch: y_out=%h sel=%b want 77 1", bus.y_out, bus.sel);
    end
    bus.p_valid = 1; bus.p = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      logic want_q;
      want_q = (i < 3);
      #1;
      checks++;
      if (bus.q_ready !== want_q || bus.p_ready !== !want_q) begin
        errors++;
        $display("FAIL drop_burst_ready[%0d]: p_ready=%b q_ready=%b want %b %b", i, bus.p_ready, bus.q_ready, !want_q, want_q);
      end
      cyc();
      checks++;
      if (bus.y_out !== (want_q ? 8'h77 : 8'hAA) || bus.sel !== want_q) begin
        errors++;
        $display("FAIL drop_burst_out[%0d]: y_out=%h sel=%b want %h %b", i, bus.y_out, bus.sel, want_q ? 8'h77 : 8'hAA, want_q);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.q_valid = 1; bus.q = 8'h99;
    cyc();
    checks++;
    if (bus.y_valid !== 1'b1 || bus.sel !== 1'b1 || bus.y_out !== 8'h99) begin
      errors++;
      $display("FAIL async_setup: y_valid=%b sel=%b y_out=%h want 1 1 99", bus.y_valid, bus.sel, bus.y_out);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (bus.y_valid !== 1'b0 || bus.sel !== 1'b0 || bus.y_out !== 8'h00 || bus.q_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_clear: y_valid=%b sel=%b y_out=%h q_ready=%b want 0 0 00 0", bus.y_valid, bus.sel, bus.y_out, bus.q_ready);
    end
    cyc();
    rst_n = 1;
    bus.p_valid = 1; bus.p = 8'hE1; bus.q = 8'hE2;
    for (int i = 0; i < 5; i++) begin
      logic want_q;
      want_q = (i == 4);
      #1;
      checks++;
      if (bus.p_ready !== !want_q || bus.q_ready !== want_q) begin
        errors++;
        $display("FAIL async_restart_ready[%0d]: p_ready=%b q_ready=%b want %b %b", i, bus.p_ready, bus.q_ready, !want_q, want_q);
      end
      cyc();
      checks++;
      if (bus.y_out !== (want_q ? 8'hE2 : 8'hE1)) begin
        errors++;
        $display("FAIL async_restart_out[%0d]: y_out=%h want %h", i, bus.y_out, want_q ? 8'hE2 : 8'hE1);
      end
    end
  endtask

  initial begin
    bus.p_valid = 0; bus.q_valid = 0; bus.p = 0; bus.q = 0; bus.y_ready = 1;
    #1;
    test_reset();
    test_p_only();
    test_round_robin();
    test_backpressure();
    test_owner_drop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
